pc_ctrl: RTL and testbench

- Pipeline front-end controller that sequences the PC register. It arbitrates every PC redirect source (trap entry, mret, execute-stage jump/branch) and every hold source (fetch not ready, load-use hazard, multi-cycle unit busy).
- It drives the PC register's jump_flag/jump_addr pair. A hold is encoded as a jump to the current PC, so the PC register needs no extra port.
- It also generates the stall and flush controls for the IF/ID and ID/EX pipeline registers.

---
 rtl/pc_ctrl_pkg.sv | 19 +
 rtl/pc_ctrl_if.sv | 37 +++
 rtl/pc_ctrl.sv | 158 +++++++++++++++
 tb/tb_pc_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl shared types and constants.
// State encoding, reset address and flush-counter helper.
package pc_ctrl_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam logic [ADDR_W_DEF-1:0] RESET_ADDR = '0;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        WAIT_FETCH = 2'd1,
        TRAP_DRAIN = 2'd2
    } pc_state_e;

    // Counter load value: the redirect cycle itself is the first flush cycle.
    function automatic logic [1:0] flush_load(input int cycles);
        return 2'(cycles - 1);
    endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// pc_ctrl front-end bus.
// Redirect/hold sources in, PC-register and pipeline controls out.
interface pc_ctrl_if #(
    parameter int ADDR_W = 32
);

    logic [ADDR_W-1:0] pc_cur;
    logic              ifetch_ready;
    logic              ex_jump_flag;
    logic [ADDR_W-1:0] ex_jump_addr;
    logic [ADDR_W-1:0] ex_pc;
    logic              load_use_stall;
    logic              mdu_busy;
    logic              int_req;
    logic [ADDR_W-1:0] int_vec;
    logic              mret_req;
    logic [ADDR_W-1:0] mepc;
    logic              jump_flag;
    logic [ADDR_W-1:0] jump_addr;
    logic              stall_o;
    logic              flush_o;
    logic              int_ack;
    logic [ADDR_W-1:0] trap_epc;

    modport master (
        input  pc_cur, ifetch_ready, ex_jump_flag, ex_jump_addr, ex_pc,
        input  load_use_stall, mdu_busy, int_req, int_vec, mret_req, mepc,
        output jump_flag, jump_addr, stall_o, flush_o, int_ack, trap_epc
    );

    modport slave (
        output pc_cur, ifetch_ready, ex_jump_flag, ex_jump_addr, ex_pc,
        output load_use_stall, mdu_busy, int_req, int_vec, mret_req, mepc,
        input  jump_flag, jump_addr, stall_o, flush_o, int_ack, trap_epc
    );

endinterface

// File: rtl/pc_ctrl.sv
// pc_ctrl: PC redirect/hold arbiter for the pipeline front end.
// A hold is a jump to pc_cur; also drives IF/ID, ID/EX stall/flush.
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int FLUSH_CYCLES = 1
) (
    input logic         clk,
    input logic         rst_n,
    pc_ctrl_if.master   bus
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;

    logic              jf;
    logic [ADDR_W-1:0] ja;
    logic              hold_stall;
    logic              flush_now;
    logic              start_flush;
    logic              ack;
    logic [ADDR_W-1:0] tepc;
    logic [ADDR_W-1:0] ex_resume;
    logic [ADDR_W-1:0] ctl_target;
    logic              flush_w;

    // Resume point of the instruction in execute, and the mret/jump target.
    always_comb begin
        ex_resume  = bus.ex_jump_flag ? bus.ex_jump_addr : bus.ex_pc;
        ctl_target = bus.mret_req ? bus.mepc : bus.ex_jump_addr;
    end

    // Next-state and redirect arbitration.
    always_comb begin
        state_d     = state_q;
        pend_addr_d = pend_addr_q;
        epc_d       = epc_q;
        flush_cnt_d = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
        jf          = 1'b0;
        ja          = '0;
        hold_stall  = 1'b0;
        flush_now   = 1'b0;
        start_flush = 1'b0;
        ack         = 1'b0;
        tepc        = '0;
        unique case (state_q)
            RUN: begin
                if (bus.int_req) begin
                    if (!bus.mdu_busy && bus.ifetch_ready) begin
                        jf          = 1'b1;
                        ja          = bus.int_vec;
                        ack         = 1'b1;
                        tepc        = ex_resume;
                        start_flush = 1'b1;
                    end else begin
                        jf         = 1'b1;
                        ja         = bus.pc_cur;
                        hold_stall = 1'b1;
                        epc_d      = ex_resume;
                        state_d    = TRAP_DRAIN;
                    end
                end else if (bus.mret_req || bus.ex_jump_flag) begin
                    jf = 1'b1;
                    if (bus.ifetch_ready) begin
                        ja          = ctl_target;
                        start_flush = 1'b1;
                    end else begin
                        ja          = bus.pc_cur;
                        pend_addr_d = ctl_target;
                        flush_now   = 1'b1;
                        state_d     = WAIT_FETCH;
                    end
                end else if (bus.load_use_stall || bus.mdu_busy ||
                             !bus.ifetch_ready) begin
                    jf         = 1'b1;
                    ja         = bus.pc_cur;
                    hold_stall = 1'b1;
                end
            end
            WAIT_FETCH: begin
                if (bus.int_req) begin
                    jf          = 1'b1;
                    ja          = bus.pc_cur;
                    hold_stall  = 1'b1;
                    epc_d       = pend_addr_q;
                    pend_addr_d = '0;
                    state_d     = TRAP_DRAIN;
                end else if (bus.ifetch_ready) begin
                    jf          = 1'b1;
                    ja          = pend_addr_q;
                    start_flush = 1'b1;
                    state_d     = RUN;
                end else begin
                    jf         = 1'b1;
                    ja         = bus.pc_cur;
                    hold_stall = 1'b1;
                end
            end
            TRAP_DRAIN: begin
                if (!bus.mdu_busy && bus.ifetch_ready) begin
                    jf          = 1'b1;
                    ja          = bus.int_vec;
                    ack         = 1'b1;
                    tepc        = epc_q;
                    start_flush = 1'b1;
                    state_d     = RUN;
                end else begin
                    jf         = 1'b1;
                    ja         = bus.pc_cur;
                    hold_stall = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        if (start_flush) begin
            flush_cnt_d = flush_load(FLUSH_CYCLES);
        end
    end

    // State, pending target, saved epc and flush counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            pend_addr_q <= '0;
            epc_q       <= '0;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            epc_q       <= epc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign flush_w = start_flush | flush_now | (flush_cnt_q != 2'd0);

    // Outputs forced low in reset; flush wins over stall.
    always_comb begin
        bus.jump_flag = 1'b0;
        bus.jump_addr = '0;
        bus.stall_o   = 1'b0;
        bus.flush_o   = 1'b0;
        bus.int_ack   = 1'b0;
        bus.trap_epc  = '0;
        if (rst_n) begin
            bus.jump_flag = jf;
            bus.jump_addr = ja;
            bus.flush_o   = flush_w;
            bus.stall_o   = hold_stall & ~flush_w;
            bus.int_ack   = ack;
            bus.trap_epc  = tepc;
        end
    end

endmodule

// File: tb/tb_pc_ctrl.sv
// Testbench for pc_ctrl: directed vector table plus randomized
// traffic checked against a behavioural model.
module tb_pc_ctrl;

    localparam int AW = 32;
    localparam int FC = 2;

    logic clk;
    logic rst_n;

    pc_ctrl_if #(.ADDR_W(AW)) bus ();

    pc_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          jf;
        logic [AW-1:0] ja;
        logic          stall;
        logic          flush;
        logic          ack;
        logic [AW-1:0] epc;
    } out_t;

    typedef struct {
        string         name;
        logic          rst;
        logic [AW-1:0] pc;
        logic          intr;
        logic          mret;
        logic          exj;
        logic [AW-1:0] exa;
        logic [AW-1:0] expc;
        logic          lu;
        logic          mdu;
        logic          rdy;
        out_t          exp;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[$];

    function automatic out_t mk(input logic jf, input logic [AW-1:0] ja,
                                input logic st, input logic fl,
                                input logic ak, input logic [AW-1:0] ep);
        out_t o;
        o.jf = jf; o.ja = ja; o.stall = st; o.flush = fl;
        o.ack = ak; o.epc = ep;
        return o;
    endfunction

    function automatic void add(input string n, input logic rs,
                                input logic [AW-1:0] pc, input logic it,
                                input logic mr, input logic ej,
                                input logic [AW-1:0] ea,
                                input logic [AW-1:0] ep, input logic lu,
                                input logic md, input logic rd,
                                input out_t e);
        vec_t v;
        v.name = n; v.rst = rs; v.pc = pc; v.intr = it; v.mret = mr;
        v.exj = ej; v.exa = ea; v.expc = ep; v.lu = lu; v.mdu = md;
        v.rdy = rd; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic out_t dut_out();
        return mk(bus.jump_flag, bus.jump_addr, bus.stall_o, bus.flush_o,
                  bus.int_ack, bus.trap_epc);
    endfunction

    task automatic check(input string n, input out_t got, input out_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got jf=%b ja=%h st=%b fl=%b ack=%b epc=%h want jf=%b ja=%h st=%b fl=%b ack=%b epc=%h",
                     n, got.jf, got.ja, got.stall, got.flush, got.ack,
                     got.epc, exp.jf, exp.ja, exp.stall, exp.flush,
                     exp.ack, exp.epc);
        end
    endtask

    // Behavioural reference: what the front end owes, per cycle.
    bit            m_waiting;
    logic [AW-1:0] m_target;
    bit            m_trap;
    logic [AW-1:0] m_epc;
    int            m_flush_left;
    bit            n_waiting;
    logic [AW-1:0] n_target;
    bit            n_trap;
    logic [AW-1:0] n_epc;
    int            n_flush_left;

    task automatic model_eval(output out_t o);
        bit redirect;
        bit kill;
        bit want_hold;
        logic [AW-1:0] dest;
        o = '0;
        redirect = 0; kill = 0; want_hold = 0; dest = '0;
        n_waiting = m_waiting; n_target = m_target;
        n_trap = m_trap; n_epc = m_epc;
        if (!rst_n) begin
            n_waiting = 0; n_target = '0; n_trap = 0; n_epc = '0;
            n_flush_left = 0;
            return;
        end
        if (m_trap) begin
            if (!bus.mdu_busy && bus.ifetch_ready) begin
                redirect = 1; dest = bus.int_vec;
                o.ack = 1; o.epc = m_epc; n_trap = 0;
            end else want_hold = 1;
        end else if (m_waiting) begin
            if (bus.int_req) begin
                want_hold = 1; n_trap = 1; n_epc = m_target;
                n_waiting = 0; n_target = '0;
            end else if (bus.ifetch_ready) begin
                redirect = 1; dest = m_target; n_waiting = 0;
            end else want_hold = 1;
        end else if (bus.int_req) begin
            if (!bus.mdu_busy && bus.ifetch_ready) begin
                redirect = 1; dest = bus.int_vec; o.ack = 1;
                o.epc = bus.ex_jump_flag ? bus.ex_jump_addr : bus.ex_pc;
            end else begin
                want_hold = 1; n_trap = 1;
                n_epc = bus.ex_jump_flag ? bus.ex_jump_addr : bus.ex_pc;
            end
        end else if (bus.mret_req || bus.ex_jump_flag) begin
            dest = bus.mret_req ? bus.mepc : bus.ex_jump_addr;
            if (bus.ifetch_ready) redirect = 1;
            else begin
                kill = 1; n_waiting = 1; n_target = dest;
                o.jf = 1; o.ja = bus.pc_cur;
            end
        end else if (bus.load_use_stall || bus.mdu_busy ||
                     !bus.ifetch_ready) begin
            want_hold = 1;
        end
        if (redirect) begin
            o.jf = 1; o.ja = dest;
        end
        if (want_hold) begin
            o.jf = 1; o.ja = bus.pc_cur;
        end
        o.flush = redirect || kill || (m_flush_left > 0);
        o.stall = want_hold && !o.flush;
        if (redirect) n_flush_left = FC - 1;
        else n_flush_left = (m_flush_left > 0) ? m_flush_left - 1 : 0;
    endtask

    task automatic model_commit();
        m_waiting = n_waiting; m_target = n_target;
        m_trap = n_trap; m_epc = n_epc; m_flush_left = n_flush_left;
    endtask

    initial begin
        out_t e;
        out_t z;
        logic [AW-1:0] pc;
        z = '0;
        bus.int_vec = 32'h1000;
        bus.mepc    = 32'h300;

        add("rst0",    0, 32'h10,   0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("wf_ent",  1, 32'h10,   0,0,1,32'h100,32'h0,  0,0,0, mk(1,32'h10,0,1,0,0));
        add("rst_wf",  0, 32'h10,   0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("post_rst",1, 32'h14,   0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("jmp80",   1, 32'h18,   0,0,1,32'h80, 32'h0,  0,0,1, mk(1,32'h80,0,1,0,0));
        add("jmp80_f2",1, 32'h80,   0,0,0,32'h0,  32'h0,  0,0,1, mk(0,0,0,1,0,0));
        add("jmp80_f3",1, 32'h84,   0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("jmp40_w1",1, 32'h88,   0,0,1,32'h40, 32'h0,  0,0,0, mk(1,32'h88,0,1,0,0));
        add("jmp40_w2",1, 32'h88,   0,0,1,32'h60, 32'h0,  0,0,0, mk(1,32'h88,1,0,0,0));
        add("jmp40_w3",1, 32'h88,   0,0,1,32'h60, 32'h0,  0,0,0, mk(1,32'h88,1,0,0,0));
        add("jmp40_go",1, 32'h88,   0,0,1,32'h60, 32'h0,  0,0,1, mk(1,32'h40,0,1,0,0));
        add("jmp40_f2",1, 32'h40,   0,0,0,32'h0,  32'h0,  0,0,1, mk(0,0,0,1,0,0));
        add("jmp40_f3",1, 32'h44,   0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("trap_h1", 1, 32'h48,   1,0,0,32'h0,  32'h200,0,1,1, mk(1,32'h48,1,0,0,0));
        add("trap_h2", 1, 32'h48,   1,0,0,32'h0,  32'h999,0,1,1, mk(1,32'h48,1,0,0,0));
        add("trap_h3", 1, 32'h48,   1,0,0,32'h0,  32'h999,0,1,1, mk(1,32'h48,1,0,0,0));
        add("trap_h4", 1, 32'h48,   0,0,0,32'h0,  32'h999,0,1,1, mk(1,32'h48,1,0,0,0));
        add("trap_go", 1, 32'h48,   0,0,0,32'h0,  32'h999,0,0,1, mk(1,32'h1000,0,1,1,32'h200));
        add("trap_f2", 1, 32'h1000, 0,0,0,32'h0,  32'h0,  0,0,1, mk(0,0,0,1,0,0));
        add("trap_f3", 1, 32'h1004, 0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("prio3",   1, 32'h1008, 1,1,1,32'h500,32'h204,0,0,1, mk(1,32'h1000,0,1,1,32'h500));
        add("prio3_f2",1, 32'h1000, 0,0,0,32'h0,  32'h0,  0,0,1, mk(0,0,0,1,0,0));
        add("lu_hold", 1, 32'h1004, 0,0,0,32'h0,  32'h0,  1,0,1, mk(1,32'h1004,1,0,0,0));
        add("lu_after",1, 32'h1004, 0,0,0,32'h0,  32'h0,  0,0,1, z);
        add("mret",    1, 32'h1008, 0,1,0,32'h0,  32'h0,  0,0,1, mk(1,32'h300,0,1,0,0));
        add("fl_ovr_st",1,32'h300,  0,0,0,32'h0,  32'h0,  1,0,1, mk(1,32'h300,0,1,0,0));
        add("nrdy_hold",1,32'h300,  0,0,0,32'h0,  32'h0,  0,0,0, mk(1,32'h300,1,0,0,0));

        foreach (vecs[i]) begin
            rst_n              = vecs[i].rst;
            bus.pc_cur         = vecs[i].pc;
            bus.int_req        = vecs[i].intr;
            bus.mret_req       = vecs[i].mret;
            bus.ex_jump_flag   = vecs[i].exj;
            bus.ex_jump_addr   = vecs[i].exa;
            bus.ex_pc          = vecs[i].expc;
            bus.load_use_stall = vecs[i].lu;
            bus.mdu_busy       = vecs[i].mdu;
            bus.ifetch_ready   = vecs[i].rdy;
            #2;
            check(vecs[i].name, dut_out(), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        pc = '0;
        m_waiting = 0; m_target = '0; m_trap = 0; m_epc = '0;
        m_flush_left = 0;
        for (int c = 0; c < 3000; c++) begin
            rst_n              = (c == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            bus.pc_cur         = pc;
            bus.int_req        = ($urandom_range(0, 19) == 0);
            bus.mret_req       = ($urandom_range(0, 11) == 0);
            bus.ex_jump_flag   = ($urandom_range(0, 5) == 0);
            bus.ex_jump_addr   = $urandom;
            bus.ex_pc          = $urandom;
            bus.load_use_stall = ($urandom_range(0, 7) == 0);
            bus.mdu_busy       = ($urandom_range(0, 5) == 0);
            bus.ifetch_ready   = ($urandom_range(0, 3) != 0);
            bus.int_vec        = $urandom;
            bus.mepc           = $urandom;
            #2;
            model_eval(e);
            check("rand", dut_out(), e);
            @(posedge clk);
            model_commit();
            if (!rst_n) pc = '0;
            else pc = e.jf ? e.ja : pc + 32'd4;
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
